// File: rtl/pc_sequencer_if.sv
// Link between the PC sequencer and the downstream return-address stack.
// The sequencer owns the strobes and the return address; the stack owns its top entry.
interface pc_sequencer_if #(
  parameter int PC_W = 11
);
  logic            stack_push;
  logic            stack_pop;
  logic            stack_select;
  logic            stack_clear;
  logic [PC_W-1:0] stack_ret_addr;
  logic [PC_W-1:0] stack_top;

  modport master (
    output stack_push, stack_pop, stack_select, stack_clear, stack_ret_addr,
    input  stack_top
  );
  modport slave (
    input  stack_push, stack_pop, stack_select, stack_clear, stack_ret_addr,
    output stack_top
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: INC/JMP/CALL/RET/SKIP/BR with return-stack depth
// tracking. Stack overflow and underflow park the core in HALT until reset.
module pc_sequencer #(
  parameter int              PC_W         = 11,
  parameter int              STACK_DEPTH  = 8,
  parameter logic [PC_W-1:0] RESET_VECTOR = '0
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             enable,
  input  logic [2:0]       op,
  input  logic             cond,
  input  logic [PC_W-1:0]  target,
  output logic [PC_W-1:0]  pc,
  output logic [3:0]       depth,
  output logic             fault,
  output logic [1:0]       fault_code,
  pc_sequencer_if.master   stk
);

  typedef enum logic [1:0] {ST_RUN, ST_SKIP, ST_HALT} state_t;

  localparam logic [2:0] OP_INC  = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_CALL = 3'd2;
  localparam logic [2:0] OP_RET  = 3'd3;
  localparam logic [2:0] OP_SKIP = 3'd4;
  localparam logic [2:0] OP_BR   = 3'd5;
  localparam logic [3:0] DEPTH_MAX = 4'(STACK_DEPTH);

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc_nxt, pc_inc;
  logic [3:0]      depth_nxt;
  logic            fault_nxt;
  logic [1:0]      fault_code_nxt;
  logic            push, pop, sel;

  assign pc_inc             = pc + PC_W'(1);
  assign stk.stack_ret_addr = pc_inc;
  assign stk.stack_clear    = ~clear_n;
  // Strobes are masked during reset so the stack only ever sees the clear.
  assign stk.stack_push     = push & clear_n;
  assign stk.stack_pop      = pop & clear_n;
  assign stk.stack_select   = sel & clear_n;

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    depth_nxt      = depth;
    fault_nxt      = fault;
    fault_code_nxt = fault_code;
    push           = 1'b0;
    pop            = 1'b0;
    sel            = 1'b0;
    if (enable) begin
      case (state)
        ST_RUN: begin
          case (op)
            OP_JMP: pc_nxt = target;
            OP_CALL: begin
              if (depth < DEPTH_MAX) begin
                push      = 1'b1;
                sel       = 1'b1;
                pc_nxt    = target;
                depth_nxt = depth + 4'd1;
              end else begin
                fault_nxt      = 1'b1;
                fault_code_nxt = 2'b01;
                state_nxt      = ST_HALT;
              end
            end
            OP_RET: begin
              if (depth != 4'd0) begin
                pop       = 1'b1;
                pc_nxt    = stk.stack_top;
                depth_nxt = depth - 4'd1;
              end else begin
                fault_nxt      = 1'b1;
                fault_code_nxt = 2'b10;
                state_nxt      = ST_HALT;
              end
            end
            OP_SKIP: begin
              pc_nxt = pc_inc;
              if (cond) state_nxt = ST_SKIP;
            end
            OP_BR:   pc_nxt = cond ? target : pc_inc;
            default: pc_nxt = pc_inc;
          endcase
        end
        // Killed op: advance past it without touching the stack or fault logic.
        ST_SKIP: begin
          pc_nxt    = pc_inc;
          state_nxt = ST_RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state      <= ST_RUN;
      pc         <= RESET_VECTOR;
      depth      <= 4'd0;
      fault      <= 1'b0;
      fault_code <= 2'b00;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      depth      <= depth_nxt;
      fault      <= fault_nxt;
      fault_code <= fault_code_nxt;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: inputs change 1ns after the rising edge,
// strobes are checked before the next edge, registered outputs after it.
module tb_pc_sequencer;
  localparam int PC_W = 11;
  localparam logic [2:0] OP_INC = 3'd0, OP_JMP = 3'd1, OP_CALL = 3'd2,
                         OP_RET = 3'd3, OP_SKIP = 3'd4, OP_BR = 3'd5;

  logic            clk = 1'b0;
  logic            clear_n;
  logic            enable;
  logic [2:0]      op;
  logic            cond;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] pc;
  logic [3:0]      depth;
  logic            fault;
  logic [1:0]      fault_code;
  int              n_cmp = 0;
  int              n_bad = 0;

  pc_sequencer_if #(.PC_W(PC_W)) stk ();

  pc_sequencer #(.PC_W(PC_W), .STACK_DEPTH(8), .RESET_VECTOR('0)) dut (
    .clk(clk), .clear_n(clear_n), .enable(enable), .op(op), .cond(cond),
    .target(target), .pc(pc), .depth(depth), .fault(fault),
    .fault_code(fault_code), .stk(stk.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply an op; returns 1ns later so combinational strobes can be checked.
  task automatic set_op(input logic [2:0] o, input logic c, input logic [PC_W-1:0] t,
                        input logic [PC_W-1:0] top);
    enable = 1'b1;
    op = o;
    cond = c;
    target = t;
    stk.stack_top = top;
    #1;
  endtask

  task automatic do_reset();
    clear_n = 1'b0;
    enable = 1'b0;
    #1;
    chk("rst_clear", 32'(stk.stack_clear), 1);
    tick();
    clear_n = 1'b1;
  endtask

  initial begin
    clear_n = 1'b0; enable = 1'b1; op = OP_CALL; cond = 1'b1; target = '0;
    stk.stack_top = '0;
    #1;
    chk("rst_clear_strobe", 32'(stk.stack_clear), 1);
    chk("rst_no_push", 32'(stk.stack_push), 0);
    tick(); tick();
    chk("rst_pc", 32'(pc), 0);
    chk("rst_depth", 32'(depth), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_code", 32'(fault_code), 0);
    clear_n = 1'b1;

    // Three increments from the reset vector.
    set_op(OP_INC, 1'b0, '0, '0);
    chk("run_clear_low", 32'(stk.stack_clear), 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("inc_pc%0d", i), 32'(pc), 32'(i));
    end
    chk("inc_depth", 32'(depth), 0);

    // CALL / RET pair.
    set_op(OP_JMP, 1'b0, 11'h010, '0); tick();
    chk("jmp_pc", 32'(pc), 32'h010);
    set_op(OP_CALL, 1'b0, 11'h200, '0);
    chk("call_push", 32'(stk.stack_push), 1);
    chk("call_sel", 32'(stk.stack_select), 1);
    chk("call_nopop", 32'(stk.stack_pop), 0);
    chk("call_ret_addr", 32'(stk.stack_ret_addr), 32'h011);
    tick();
    chk("call_pc", 32'(pc), 32'h200);
    chk("call_depth", 32'(depth), 1);
    set_op(OP_RET, 1'b0, '0, 11'h011);
    chk("ret_pop", 32'(stk.stack_pop), 1);
    chk("ret_nopush", 32'(stk.stack_push), 0);
    tick();
    chk("ret_pc", 32'(pc), 32'h011);
    chk("ret_depth", 32'(depth), 0);

    // Overflow on the ninth nested call.
    for (int i = 0; i < 8; i++) begin
      set_op(OP_CALL, 1'b0, 11'(32'h100 + i), '0);
      tick();
    end
    chk("nest_depth", 32'(depth), 8);
    chk("nest_pc", 32'(pc), 32'h107);
    set_op(OP_CALL, 1'b0, 11'h300, '0);
    chk("ovf_nopush", 32'(stk.stack_push), 0);
    tick();
    chk("ovf_pc", 32'(pc), 32'h107);
    chk("ovf_fault", 32'(fault), 1);
    chk("ovf_code", 32'(fault_code), 1);
    set_op(OP_RET, 1'b0, '0, 11'h055);
    chk("halt_nopop", 32'(stk.stack_pop), 0);
    tick();
    chk("halt_pc", 32'(pc), 32'h107);
    chk("halt_depth", 32'(depth), 8);
    chk("halt_code", 32'(fault_code), 1);
    do_reset();
    chk("ovf_rst_fault", 32'(fault), 0);

    // Underflow.
    set_op(OP_RET, 1'b0, '0, 11'h123);
    chk("unf_nopop", 32'(stk.stack_pop), 0);
    tick();
    chk("unf_pc", 32'(pc), 0);
    chk("unf_fault", 32'(fault), 1);
    chk("unf_code", 32'(fault_code), 2);
    set_op(OP_INC, 1'b0, '0, '0); tick();
    chk("unf_halt_pc", 32'(pc), 0);
    do_reset();

    // Skip with enable gaps, then a killed CALL.
    set_op(OP_JMP, 1'b0, 11'h020, '0); tick();
    set_op(OP_SKIP, 1'b1, '0, '0); tick();
    chk("skip_pc", 32'(pc), 32'h021);
    enable = 1'b0; op = OP_CALL; target = 11'h300;
    #1;
    chk("dis_nopush", 32'(stk.stack_push), 0);
    tick(); tick();
    chk("dis_pc", 32'(pc), 32'h021);
    set_op(OP_CALL, 1'b0, 11'h300, '0);
    chk("kill_nopush", 32'(stk.stack_push), 0);
    tick();
    chk("kill_pc", 32'(pc), 32'h022);
    chk("kill_depth", 32'(depth), 0);
    set_op(OP_SKIP, 1'b0, '0, '0); tick();
    chk("skip0_pc", 32'(pc), 32'h023);
    set_op(OP_CALL, 1'b0, 11'h050, '0);
    chk("skip0_push", 32'(stk.stack_push), 1);
    tick();
    chk("skip0_call_pc", 32'(pc), 32'h050);
    chk("skip0_depth", 32'(depth), 1);

    // Wrap and branches.
    set_op(OP_JMP, 1'b0, 11'h7FF, '0); tick();
    chk("wrap_ret_addr", 32'(stk.stack_ret_addr), 0);
    set_op(OP_INC, 1'b0, '0, '0); tick();
    chk("wrap_pc", 32'(pc), 0);
    set_op(OP_BR, 1'b1, 11'h155, '0); tick();
    chk("br1_pc", 32'(pc), 32'h155);
    set_op(OP_BR, 1'b0, 11'h2AA, '0); tick();
    chk("br0_pc", 32'(pc), 32'h156);
    set_op(3'd7, 1'b1, 11'h3FF, '0); tick();
    chk("op7_pc", 32'(pc), 32'h157);

    // Reset while a skip is pending returns to RUN.
    set_op(OP_SKIP, 1'b1, '0, '0); tick();
    chk("pre_rst_pc", 32'(pc), 32'h158);
    do_reset();
    chk("skip_rst_pc", 32'(pc), 0);
    chk("skip_rst_depth", 32'(depth), 0);
    set_op(OP_CALL, 1'b0, 11'h222, '0);
    chk("post_rst_push", 32'(stk.stack_push), 1);
    tick();
    chk("post_rst_pc", 32'(pc), 32'h222);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- 11-bit program-counter sequencer for the MicroEV20 core; sits directly upstream of the return-address stack.
- Each enabled cycle it executes one flow-control op: increment, jump, call, return, conditional skip or conditional branch.
- Drives the stack's push/pop/select/clear strobes and return-address data, consumes the stack top on RET, and tracks stack depth so that overflow and underflow are trapped before the stack is corrupted.

Parameters:
- PC_W, 11, program counter and stack data width.
- STACK_DEPTH, 8, number of entries in the downstream return stack.
- RESET_VECTOR, 11'h000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- clear_n  input  1  synchronous active-low reset.
- enable  input  1  advance one op this cycle; when low, all state holds and all strobes are 0.
- op  input  3  0=INC, 1=JMP, 2=CALL, 3=RET, 4=SKIP, 5=BR; 6 and 7 are treated as INC.
- cond  input  1  condition for SKIP/BR.
- target  input  PC_W  jump/call/branch destination (instruction address field).
- stack_top  input  PC_W  current top of the return stack, combinationally valid.
- pc  output  PC_W  current program counter (registered).
- stack_push  output  1  push strobe to the stack.
- stack_pop  output  1  pop strobe to the stack.
- stack_select  output  1  1 selects stack_ret_addr (I1); 0 selects target (I2).
- stack_clear  output  1  stack clear strobe.
- stack_ret_addr  output  PC_W  pc+1 mod 2^PC_W, the return address to push.
- depth  output  4  current stack occupancy, 0..STACK_DEPTH.
- fault  output  1  sticky: overflow or underflow trapped.
- fault_code  output  2  00 none, 01 overflow, 10 underflow.

Behaviour:
- Reset (clear_n=0 at a clk edge):
  - pc=RESET_VECTOR, depth=0, fault=0, fault_code=00, state=RUN.
  - stack_clear=1 during every reset cycle; all other strobes 0.
  - Reset overrides every other input, including mid-skip and HALT.
- Outputs:
  - Strobes are combinational from state, op, cond, enable and depth; they act on the same clk edge that updates pc.
  - stack_ret_addr = pc+1, which wraps 0x7FF to 0x000.
- States:
  - RUN → SKIP when op=SKIP and cond=1.
  - SKIP → RUN after the next enabled op, which is killed.
  - Any state → HALT on fault. HALT is exited only by reset.
- RUN, enable=1:
  - INC: pc<=pc+1 (wraps).
  - JMP: pc<=target.
  - CALL with depth<STACK_DEPTH: stack_push=1, stack_select=1, pc<=target, depth+1.
  - CALL with depth==STACK_DEPTH: no push, pc holds, fault=1, fault_code=01, go to HALT.
  - RET with depth>0: stack_pop=1, pc<=stack_top, depth-1.
  - RET with depth==0: no pop, pc holds, fault=1, fault_code=10, go to HALT.
  - SKIP: pc<=pc+1; if cond=1, go to SKIP.
  - BR: pc<=target if cond=1, else pc+1.
- SKIP, enable=1: the op is killed and behaves as INC (no strobes, no fault check even for CALL/RET); go to RUN.
- enable=0: no state change in any state; a pending skip is retained until the next enabled cycle.
- HALT: pc, depth and fault hold; all strobes 0.
- Strobe exclusivity: stack_push and stack_pop are never both 1 in the same cycle.
- Latency: one cycle from op to new pc for every op. No bubbles.

Test Plan:
- Reset then 3 enabled INC → pc 000,001,002,003; stack_clear=1 only during reset; depth=0.
- pc=0x010, CALL target=0x200 → push=1, select=1, ret_addr=0x011, pc=0x200, depth=1. Then RET with stack_top=0x011 → pop=1, pc=0x011, depth=0.
- 8 nested CALLs → depth=8. 9th CALL → no push, pc unchanged, fault=1, code=01. Subsequent ops (including enable=1 RET) → pc frozen until clear_n=0.
- RET at depth=0 → no pop, fault=1, code=10, HALT.
- SKIP cond=1 at pc=0x020, enable low 2 cycles, then CALL → CALL killed: no push, pc=0x022, depth unchanged. SKIP cond=0 → next op executes normally.
- pc=0x7FF INC → pc=0x000. BR cond=1 target=0x155 → pc=0x155. BR cond=0 → pc+1. Reset asserted while in SKIP → RUN, pc=000.
